// File: rtl/axil_reg_port.sv
// AXI4-Lite responder that gives a debug host one-at-a-time access to the halted core's
// four-entry register file. Accesses while the core runs, or outside the map, return SLVERR.
module axil_reg_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  input  logic              cpu_halted,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    W_EXEC = 3'd1,
    B_RESP = 3'd2,
    R_EXEC = 3'd3,
    R_RESP = 3'd4
  } state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return (addr[ADDR_W-1:4] == '0);
  endfunction

  state_e            state_q, state_d;
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [1:0]        aw_idx_q, aw_idx_d;
  logic              aw_dec_q, aw_dec_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              strb0_q, strb0_d;
  logic [1:0]        ar_idx_q, ar_idx_d;
  logic              ar_dec_q, ar_dec_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              bvalid_q, bvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rvalid_q, rvalid_d;

  logic              awready_s, wready_s, arready_s, rf_we_s, ok_s;
  logic [31:0]       rdata_ext_s;
  logic              unused_s;

  assign unused_s = ^{s_awaddr[1:0], s_araddr[1:0], s_wdata, s_wstrb[3:1]};

  // Next-state and handshake logic for the serialized write/read engine
  always_comb begin
    state_d     = state_q;
    aw_held_d   = aw_held_q;
    w_held_d    = w_held_q;
    aw_idx_d    = aw_idx_q;
    aw_dec_d    = aw_dec_q;
    wdata_d     = wdata_q;
    strb0_d     = strb0_q;
    ar_idx_d    = ar_idx_q;
    ar_dec_d    = ar_dec_q;
    bresp_d     = bresp_q;
    bvalid_d    = bvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rvalid_d    = rvalid_q;
    awready_s   = 1'b0;
    wready_s    = 1'b0;
    arready_s   = 1'b0;
    rf_we_s     = 1'b0;
    ok_s        = 1'b0;
    rdata_ext_s = '0;
    rdata_ext_s[DATA_W-1:0] = rf_rdata;

    case (state_q)
      IDLE: begin
        awready_s = !aw_held_q;
        wready_s  = !w_held_q;
        // Reads only start when no write is pending or being offered
        arready_s = !aw_held_q && !w_held_q && !s_awvalid && !s_wvalid;
        if (awready_s && s_awvalid) begin
          aw_held_d = 1'b1;
          aw_idx_d  = s_awaddr[3:2];
          aw_dec_d  = addr_in_range(s_awaddr);
        end else begin
          aw_held_d = aw_held_q;
        end
        if (wready_s && s_wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata[DATA_W-1:0];
          strb0_d  = s_wstrb[0];
        end else begin
          w_held_d = w_held_q;
        end
        if (aw_held_d && w_held_d) begin
          state_d = W_EXEC;
        end else if (arready_s && s_arvalid) begin
          ar_idx_d = s_araddr[3:2];
          ar_dec_d = addr_in_range(s_araddr);
          state_d  = R_EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      W_EXEC: begin
        ok_s      = aw_dec_q && cpu_halted;
        rf_we_s   = ok_s && strb0_q;
        bresp_d   = ok_s ? RESP_OKAY : RESP_SLVERR;
        bvalid_d  = 1'b1;
        aw_held_d = 1'b0;
        w_held_d  = 1'b0;
        state_d   = B_RESP;
      end
      B_RESP: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = B_RESP;
        end
      end
      R_EXEC: begin
        ok_s     = ar_dec_q && cpu_halted;
        rdata_d  = ok_s ? rdata_ext_s : 32'h0000_0000;
        rresp_d  = ok_s ? RESP_OKAY : RESP_SLVERR;
        rvalid_d = 1'b1;
        state_d  = R_RESP;
      end
      R_RESP: begin
        if (s_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end else begin
          state_d = R_RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= 2'b00;
      aw_dec_q  <= 1'b0;
      wdata_q   <= '0;
      strb0_q   <= 1'b0;
      ar_idx_q  <= 2'b00;
      ar_dec_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bvalid_q  <= 1'b0;
      rdata_q   <= 32'h0000_0000;
      rresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      aw_dec_q  <= aw_dec_d;
      wdata_q   <= wdata_d;
      strb0_q   <= strb0_d;
      ar_idx_q  <= ar_idx_d;
      ar_dec_q  <= ar_dec_d;
      bresp_q   <= bresp_d;
      bvalid_q  <= bvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign s_awready = awready_s;
  assign s_wready  = wready_s;
  assign s_arready = arready_s;
  assign s_bresp   = bresp_q;
  assign s_bvalid  = bvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign s_rvalid  = rvalid_q;
  // rf_we must follow cpu_halted during W_EXEC itself, so it is decoded from the state
  assign rf_we     = rf_we_s;
  assign rf_waddr  = aw_idx_q;
  assign rf_wdata  = wdata_q;
  assign rf_raddr  = ar_idx_q;

endmodule

// File: tb/tb_axil_reg_port.sv
// Randomized self-checking bench for axil_reg_port against an array model of the register file.
module tb_axil_reg_port;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_awaddr, s_araddr;
  logic        s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic        cpu_halted, rf_we;
  logic [1:0]  rf_waddr, rf_raddr;
  logic [7:0]  rf_wdata, rf_rdata;

  logic [7:0]  rf_mem [4] = '{default: 8'h00};
  logic [7:0]  mdl [4] = '{default: 8'h00};
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  // Core register file environment
  assign rf_rdata = rf_mem[rf_raddr];
  always @(posedge clk) if (rf_we) rf_mem[rf_waddr] <= rf_wdata;

  axil_reg_port #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cpu_halted(cpu_halted), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
  );

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input string tag);
    bit aw_done, w_done, got_b, ok, exp_we;
    int hs_cyc, we_cyc, bv_cyc, we_cnt;
    logic [1:0] resp;
    ok = (addr[7:4] == 4'h0) && cpu_halted;
    exp_we = ok && strb[0];
    aw_done = 1'b0; w_done = 1'b0; got_b = 1'b0;
    hs_cyc = -1; we_cyc = -1; bv_cyc = -1; we_cnt = 0; resp = 2'b11;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    for (int cyc = 0; cyc < 40 && !got_b; cyc++) begin
      @(negedge clk);
      s_awvalid = !aw_done && (cyc >= aw_dly);
      s_wvalid  = !w_done && (cyc >= w_dly);
      #1;
      if (rf_we) begin
        we_cnt++; we_cyc = cyc;
        checks++;
        if (rf_waddr !== addr[3:2] || rf_wdata !== data[7:0])
          $display("FAIL %s rf_write: got idx %0d data %h expected idx %0d data %h", tag, rf_waddr, rf_wdata, addr[3:2], data[7:0]);
        else passed++;
      end
      if (s_bvalid) begin
        if (bv_cyc < 0) bv_cyc = cyc;
        checks++;
        if ((s_awready | s_wready | s_arready) !== 1'b0)
          $display("FAIL %s ready_in_bresp: got aw %b w %b ar %b expected all 0", tag, s_awready, s_wready, s_arready);
        else passed++;
        s_bready = (cyc >= bv_cyc + b_dly);
        if (s_bready) begin got_b = 1'b1; resp = s_bresp; end
      end else begin
        s_bready = 1'b0;
      end
      if (s_awvalid && s_awready) aw_done = 1'b1;
      if (s_wvalid && s_wready) w_done = 1'b1;
      if (aw_done && w_done && hs_cyc < 0) hs_cyc = cyc;
    end
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    checks++;
    if (!got_b) $display("FAIL %s b_timeout: got no response expected one within 40 cycles", tag);
    else passed++;
    checks++;
    if (resp !== (ok ? 2'b00 : 2'b10)) $display("FAIL %s bresp: got %b expected %b", tag, resp, ok ? 2'b00 : 2'b10);
    else passed++;
    checks++;
    if (we_cnt !== int'(exp_we)) $display("FAIL %s rf_we_count: got %0d expected %0d", tag, we_cnt, int'(exp_we));
    else passed++;
    if (exp_we) begin
      checks++;
      if (we_cyc !== hs_cyc + 1) $display("FAIL %s rf_we_timing: got cycle %0d expected %0d", tag, we_cyc, hs_cyc + 1);
      else passed++;
    end
    checks++;
    if (bv_cyc !== hs_cyc + 2) $display("FAIL %s bvalid_timing: got cycle %0d expected %0d", tag, bv_cyc, hs_cyc + 2);
    else passed++;
    if (exp_we) mdl[addr[3:2]] = data[7:0];
  endtask

  task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly, input string tag);
    bit ar_done, got_r, ok;
    int hs_cyc, rv_cyc;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
    ok = (addr[7:4] == 4'h0) && cpu_halted;
    exp_data = ok ? {24'h000000, mdl[addr[3:2]]} : 32'h0000_0000;
    exp_resp = ok ? 2'b00 : 2'b10;
    ar_done = 1'b0; got_r = 1'b0; hs_cyc = -1; rv_cyc = -1;
    s_araddr = addr;
    for (int cyc = 0; cyc < 40 && !got_r; cyc++) begin
      @(negedge clk);
      s_arvalid = !ar_done && (cyc >= ar_dly);
      #1;
      if (s_rvalid) begin
        if (rv_cyc < 0) rv_cyc = cyc;
        checks++;
        if (s_rdata !== exp_data || s_rresp !== exp_resp || (s_awready | s_wready | s_arready) !== 1'b0)
          $display("FAIL %s rdata_rresp: got %h/%b readies %b%b%b expected %h/%b readies 000", tag, s_rdata, s_rresp, s_awready, s_wready, s_arready, exp_data, exp_resp);
        else passed++;
        s_rready = (cyc >= rv_cyc + r_dly);
        if (s_rready) got_r = 1'b1;
      end else begin
        s_rready = 1'b0;
      end
      if (s_arvalid && s_arready) begin ar_done = 1'b1; hs_cyc = cyc; end
    end
    @(negedge clk);
    s_arvalid = 1'b0; s_rready = 1'b0;
    checks++;
    if (!got_r) $display("FAIL %s r_timeout: got no response expected one within 40 cycles", tag);
    else passed++;
    checks++;
    if (rv_cyc !== hs_cyc + 2) $display("FAIL %s rvalid_timing: got cycle %0d expected %0d", tag, rv_cyc, hs_cyc + 2);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_halted = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    s_awaddr = 8'h00; s_araddr = 8'h00; s_wdata = 32'h0; s_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready, s_arready} !== 3'b111) $display("FAIL reset readies: got %b expected 111", {s_awready, s_wready, s_arready});
    else passed++;
    checks++;
    if ({s_bvalid, s_rvalid, rf_we} !== 3'b000 || s_bresp !== 2'b00 || s_rresp !== 2'b00 || s_rdata !== 32'h0 || rf_raddr !== 2'd0)
      $display("FAIL reset outputs: got bv %b rv %b we %b bresp %b rresp %b rdata %h raddr %0d expected all zero", s_bvalid, s_rvalid, rf_we, s_bresp, s_rresp, s_rdata, rf_raddr);
    else passed++;
  endtask

  task automatic test_basic_write_read();
    cpu_halted = 1'b1;
    do_write(8'h08, 32'h0000_00A5, 4'h1, 0, 0, 0, "basic_wr");
    do_read(8'h08, 0, 0, "basic_rd");
  endtask

  task automatic test_w_before_aw();
    do_write(8'h00, {24'h0, 8'($urandom)}, 4'h1, 3, 0, 4, "w_first");
    do_read(8'h00, 0, 2, "w_first_rd");
  endtask

  task automatic test_not_halted();
    cpu_halted = 1'b0;
    do_write(8'h04, 32'h0000_005A, 4'h1, 0, 0, 0, "run_wr");
    do_read(8'h04, 0, 0, "run_rd");
    cpu_halted = 1'b1;
    do_read(8'h04, 0, 0, "run_rd_check");
  endtask

  task automatic test_bad_addr_strb();
    do_read(8'h14, 0, 0, "oor_rd");
    do_write(8'h1C, 32'h0000_0077, 4'h1, 0, 1, 0, "oor_wr");
    do_write(8'h0C, 32'h0000_00C3, 4'h0, 0, 0, 0, "strb0_wr");
    do_read(8'h0F, 1, 0, "strb0_rd");
  endtask

  task automatic test_collision();
    bit aw_done, w_done, ar_done, got_r;
    int b_cyc, ar_cyc, overlap;
    logic [7:0] d;
    logic [31:0] rd;
    d = 8'($urandom);
    aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; got_r = 1'b0;
    b_cyc = -1; ar_cyc = -1; overlap = 0; rd = 32'hFFFF_FFFF;
    s_awaddr = 8'h04; s_wdata = {24'h0, d}; s_wstrb = 4'h1; s_araddr = 8'h04;
    for (int cyc = 0; cyc < 40 && !got_r; cyc++) begin
      @(negedge clk);
      s_awvalid = !aw_done; s_wvalid = !w_done; s_arvalid = !ar_done;
      #1;
      if (rf_we && s_arvalid && s_arready) overlap++;
      if (s_awvalid && s_awready) aw_done = 1'b1;
      if (s_wvalid && s_wready) w_done = 1'b1;
      if (s_arvalid && s_arready) begin ar_done = 1'b1; ar_cyc = cyc; end
      s_bready = s_bvalid;
      if (s_bvalid) b_cyc = cyc;
      s_rready = s_rvalid;
      if (s_rvalid) begin got_r = 1'b1; rd = s_rdata; end
    end
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    checks++;
    if (ar_cyc !== b_cyc + 1 || b_cyc < 0) $display("FAIL collision ar_after_b: got ar cycle %0d expected %0d", ar_cyc, b_cyc + 1);
    else passed++;
    checks++;
    if (overlap !== 0) $display("FAIL collision overlap: got %0d expected 0", overlap);
    else passed++;
    checks++;
    if (rd !== {24'h0, d}) $display("FAIL collision rdata: got %h expected %h", rd, {24'h0, d});
    else passed++;
    mdl[1] = d;
  endtask

  task automatic test_reset_mid_write();
    int bad;
    bad = 0;
    @(negedge clk);
    s_awaddr = 8'h0C; s_wdata = {24'h0, ~mdl[3]}; s_wstrb = 4'h1;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1;
    checks++;
    if ({s_awready, s_wready} !== 2'b11) $display("FAIL rst_mid accept: got %b expected 11", {s_awready, s_wready});
    else passed++;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0) $display("FAIL rst_mid rf_we: got %b expected 0", rf_we);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (s_bvalid || rf_we) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL rst_mid no_response: got %0d bad cycles expected 0", bad);
    else passed++;
    do_read(8'h0C, 0, 0, "rst_mid_rd");
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) a[7:4] = 4'($urandom_range(1, 15));
      cpu_halted = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), "rand_wr");
      else
        do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), "rand_rd");
    end
    cpu_halted = 1'b1;
    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0, 0, "final_rd");
  endtask

  initial begin
    test_reset();
    test_basic_write_read();
    test_w_before_aw();
    test_not_halted();
    test_bad_addr_strb();
    test_collision();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/axil_reg_port.md
# axil_reg_port

AXI4-Lite responder that gives an external host (debug/bring-up master on the AXI slice) read and write access to the CPU's four-entry register file while the core is halted. It sits beside the core and drives the register file's spare write port and one read port. Write and read transactions are serialized, one in flight at a time. Accesses made while the core is running, or to out-of-range addresses, are answered with SLVERR and have no side effect.

## Interface
Parameters:
- ADDR_W, 8, AXI address width (byte address)
- DATA_W, 8, register width; must be ≤ 32

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_W  write address
- s_awvalid / s_awready  in / out  1  write-address handshake
- s_wdata  in  32  write data; bits [DATA_W-1:0] used
- s_wstrb  in  4  byte strobes; only bit 0 significant
- s_wvalid / s_wready  in / out  1  write-data handshake
- s_bresp  out  2  00 OKAY, 10 SLVERR
- s_bvalid / s_bready  out / in  1  write-response handshake
- s_araddr  in  ADDR_W  read address
- s_arvalid / s_arready  in / out  1  read-address handshake
- s_rdata  out  32  read data, zero-extended from DATA_W
- s_rresp  out  2  00 OKAY, 10 SLVERR
- s_rvalid / s_rready  out / in  1  read-data handshake
- cpu_halted  in  1  core halted; access permitted only when 1
- rf_we  out  1  register-file write enable, single-cycle pulse
- rf_waddr  out  2  register-file write index
- rf_wdata  out  DATA_W  register-file write data
- rf_raddr  out  2  register-file read index
- rf_rdata  in  DATA_W  combinational register-file read data

## Operation
- Address map: index = addr[3:2]; addr[1:0] ignored. Decode is valid iff addr[ADDR_W-1:4] == 0; otherwise SLVERR.
- States: IDLE, W_EXEC, B_RESP, R_EXEC, R_RESP.
- IDLE:
  - s_awready = !aw_held; s_wready = !w_held.
  - AW and W are captured independently, in either order or in the same cycle; the address, data and strb[0] are latched.
  - When both are held, go to W_EXEC.
  - s_arready = 1 only when aw_held = 0, w_held = 0, s_awvalid = 0 and s_wvalid = 0. Writes have priority.
  - An AR handshake latches the address and moves to R_EXEC.
- W_EXEC (one cycle):
  - ok = decode valid and cpu_halted.
  - rf_we = ok && strb0.
  - rf_waddr and rf_wdata are driven from the latches.
  - bresp is latched as ok ? OKAY : SLVERR. A valid, halted access with strb0 = 0 returns OKAY with no write.
  - Clear held flags; go to B_RESP.
- B_RESP: s_bvalid = 1 until s_bready; then go to IDLE.
- R_EXEC (one cycle):
  - rf_raddr = latched index.
  - ok = decode valid and cpu_halted.
  - s_rdata is registered as ok ? zero-extended rf_rdata : 0.
  - rresp is registered as ok ? OKAY : SLVERR.
  - Go to R_RESP.
- R_RESP: s_rvalid = 1 and s_rdata/s_rresp are held stable until s_rready; then go to IDLE.
- All ready outputs are 0 outside IDLE.
- cpu_halted is sampled only in W_EXEC and R_EXEC. A change during B_RESP or R_RESP does not alter a response already issued.
- rf_raddr holds the last latched read index at all other times. rf_waddr and rf_wdata are don't-care when rf_we = 0.

## Timing
- Reset (asynchronous, active-low): state IDLE, held flags 0, rf_we 0, s_bvalid 0, s_rvalid 0, s_bresp 00, s_rresp 00, s_rdata 0, rf_raddr 0, all latches 0. s_awready, s_wready and s_arready therefore read 1 after reset.
- Write: the later of the AW/W handshakes completes at edge N. rf_we is high during cycle N+1, and the register file updates at the end of N+1. s_bvalid rises at N+2.
- Read: AR handshake at edge N. R_EXEC occupies cycle N+1. s_rvalid rises at N+2 with data reflecting the register contents during cycle N+1.
- Back-to-back: after the B or R handshake at edge M, a new AW/W/AR can be accepted in cycle M+1. Minimum spacing between transactions is 3 cycles.
- A write and a read presented together in IDLE: the write is served first and AR waits. No cycle ever has both rf_we and a read being captured.
- Reset asserted mid-transaction aborts it: no rf_we pulse and no response are produced.

## Test plan
- Reset release with all valids low -> awready=wready=arready=1, bvalid=rvalid=0, rf_we=0.
- cpu_halted=1, AW(0x08) and W(0x000000A5, strb 0x1) in the same cycle -> rf_we single pulse with rf_waddr=2 and rf_wdata=0xA5; bvalid two cycles after the handshake; bresp=OKAY. Then AR(0x08) -> rdata=0x000000A5, rresp=OKAY.
- W sent 3 cycles before AW, with bready held low for 4 cycles -> exactly one rf_we pulse; bvalid stays high and no new AW/W/AR is accepted until the B handshake.
- cpu_halted=0, write to 0x04 -> bresp=SLVERR, no rf_we. AR(0x04) -> rresp=SLVERR, rdata=0.
- cpu_halted=1, AR(0x14) -> SLVERR. Write to 0x0C with strb=0x0 -> OKAY and no rf_we.
- Simultaneous AW+W and AR in IDLE -> write completes first, then AR is accepted the cycle after the B handshake. rst_n asserted during W_EXEC -> rf_we=0 and no response is issued.
